// File: rtl/max_scan_unit.sv
// Streaming max-finder: scans COUNT samples per block, tracking the running maximum and its index.
// Optional build macro MAX_SCAN_SIGNED_EN switches the compare to two's complement.
module max_scan_unit #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_WIDTH  = 3,
    parameter int unsigned COUNT      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Start,
    input  logic                  Clear,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [DATA_WIDTH-1:0] In_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] MAX,
    output logic [IDX_WIDTH-1:0]  Max_Number,
    output logic [IDX_WIDTH:0]    Accepted
);

    localparam int unsigned ACC_WIDTH = IDX_WIDTH + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_LAST = ACC_WIDTH'(COUNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_max;
    logic [DATA_WIDTH-1:0]  w_max_nxt;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [IDX_WIDTH-1:0]   w_idx_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   w_acc_nxt;
    logic [ACC_WIDTH-1:0]   w_acc_inc;
    logic                   r_in_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_greater;
    logic                   w_xfer;

    // Same ordering as the downstream comparator; ties keep the incumbent.
`ifdef MAX_SCAN_SIGNED_EN
    assign w_greater = $signed(In_Data) > $signed(r_max);
`else
    assign w_greater = In_Data > r_max;
`endif

    assign w_xfer    = In_Valid && (r_state == S_SCAN);
    assign w_acc_inc = r_acc + ACC_WIDTH'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_max      <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_max      <= w_max_nxt;
            r_idx      <= w_idx_nxt;
            r_acc      <= w_acc_nxt;
            r_in_ready <= (w_state_nxt == S_SCAN);
            r_busy     <= (w_state_nxt == S_SCAN);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_max_nxt   = r_max;
        w_idx_nxt   = r_idx;
        w_acc_nxt   = r_acc;

        if (Clear) begin
            w_state_nxt = S_IDLE;
            w_max_nxt   = '0;
            w_idx_nxt   = '0;
            w_acc_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        w_state_nxt = S_SCAN;
                        w_max_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_acc_nxt   = '0;
                    end
                end
                S_SCAN: begin
                    if (w_xfer) begin
                        // First sample of a block loads regardless of value.
                        if (r_acc == '0) begin
                            w_max_nxt = In_Data;
                            w_idx_nxt = '0;
                        end else if (w_greater) begin
                            w_max_nxt = In_Data;
                            w_idx_nxt = r_acc[IDX_WIDTH-1:0];
                        end
                        w_acc_nxt = w_acc_inc;
                        if (w_acc_inc == ACC_LAST) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign In_Ready   = r_in_ready;
    assign Busy       = r_busy;
    assign Done       = r_done;
    assign MAX        = r_max;
    assign Max_Number = r_idx;
    assign Accepted   = r_acc;

endmodule

// File: tb/tb_max_scan_unit.sv
// Self-checking bench for max_scan_unit; block expectations come from a reference model via a queue.
module tb_max_scan_unit;

    localparam int unsigned DW  = 16;
    localparam int unsigned IW  = 3;
    localparam int unsigned CNT = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Start = 1'b0;
    logic          Clear = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [DW-1:0] In_Data = '0;
    logic          Busy;
    logic          Done;
    logic [DW-1:0] MAX;
    logic [IW-1:0] Max_Number;
    logic [IW:0]   Accepted;

    typedef logic [DW-1:0] blk_t [CNT];
    typedef struct packed {
        logic [DW-1:0] mx;
        logic [IW-1:0] idx;
        logic [IW:0]   acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    max_scan_unit #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .COUNT(CNT)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Clear(Clear),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
        .Busy(Busy), .Done(Done), .MAX(MAX), .Max_Number(Max_Number),
        .Accepted(Accepted)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input blk_t s);
        exp_t e;
        bit   gt;
        e.mx  = s[0];
        e.idx = '0;
        e.acc = (IW+1)'(CNT);
        for (int i = 1; i < CNT; i++) begin
`ifdef MAX_SCAN_SIGNED_EN
            gt = $signed(s[i]) > $signed(e.mx);
`else
            gt = s[i] > e.mx;
`endif
            if (gt) begin
                e.mx  = s[i];
                e.idx = IW'(i);
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Starts a block, streams it, returns right after the edge of the final transfer.
    task automatic drive_block(input blk_t s, input bit bubbles, input int start_at);
        q.push_back(model(s));
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < CNT; i++) begin
            In_Valid = 1'b1;
            In_Data  = s[i];
            Start    = (i == start_at);
            step();
            Start    = 1'b0;
            In_Valid = 1'b0;
            if (bubbles && i < CNT - 1) step();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        n_cmp++;
        if ({In_Ready, Busy, Done} !== 3'b000 || MAX !== '0 || Max_Number !== '0 || Accepted !== '0) begin
            n_fail++;
            $display("FAIL reset: rdy/busy/done=%b%b%b max=%h idx=%0d acc=%0d want all zero",
                     In_Ready, Busy, Done, MAX, Max_Number, Accepted);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic();
        blk_t b;
        exp_t e;
        b = '{16'd3, 16'd9, 16'd2, 16'd7, 16'd1, 16'd8, 16'd0, 16'd4};
        drive_block(b, 1'b0, -1);
        e = q.pop_front();
        n_cmp++;
        if (Done !== 1'b1 || In_Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: done=%b rdy=%b want 1/0", Done, In_Ready);
        end
        n_cmp++;
        if (MAX !== e.mx || Max_Number !== e.idx || Accepted !== e.acc || MAX !== 16'd9) begin
            n_fail++;
            $display("FAIL basic_result: max=%h idx=%0d acc=%0d want %h/%0d/%0d",
                     MAX, Max_Number, Accepted, e.mx, e.idx, e.acc);
        end
        step();
        n_cmp++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_width: done=%b busy=%b want 0/0", Done, Busy);
        end
    endtask

    task automatic test_hold();
        step();
        step();
        n_cmp++;
        if (MAX !== 16'd9 || Max_Number !== 3'd1 || Accepted !== 4'd8) begin
            n_fail++;
            $display("FAIL idle_hold: max=%h idx=%0d acc=%0d want 0009/1/8", MAX, Max_Number, Accepted);
        end
        Start = 1'b1;
        step();
        Start = 1'b0;
        n_cmp++;
        if (MAX !== '0 || Accepted !== '0 || Busy !== 1'b1 || In_Ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_clears: max=%h acc=%0d busy=%b rdy=%b want 0/0/1/1", MAX, Accepted, Busy, In_Ready);
        end
        Clear = 1'b1;
        step();
        Clear = 1'b0;
    endtask

    task automatic test_ties();
        blk_t b;
        exp_t e;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < CNT; i++) b[i] = (t == 0) ? 16'd5 : 16'd0;
            drive_block(b, 1'b0, -1);
            e = q.pop_front();
            n_cmp++;
            if (Done !== 1'b1 || MAX !== e.mx || Max_Number !== e.idx || Accepted !== e.acc) begin
                n_fail++;
                $display("FAIL ties_%0d: done=%b max=%h idx=%0d acc=%0d want 1/%h/%0d/%0d",
                         t, Done, MAX, Max_Number, Accepted, e.mx, e.idx, e.acc);
            end
            step();
        end
    endtask

    task automatic test_bubbles();
        blk_t b;
        exp_t e;
        for (int i = 0; i < CNT - 1; i++) b[i] = DW'(i + 1);
        b[CNT-1] = 16'hFFFF;
        drive_block(b, 1'b1, -1);
        e = q.pop_front();
        n_cmp++;
        if (Done !== 1'b1 || MAX !== e.mx || Max_Number !== e.idx || Max_Number !== 3'd7) begin
            n_fail++;
            $display("FAIL bubbles: done=%b max=%h idx=%0d want 1/%h/%0d", Done, MAX, Max_Number, e.mx, e.idx);
        end
        step();
    endtask

    task automatic test_start_ignored();
        blk_t b;
        exp_t e;
        b = '{16'h0010, 16'h0300, 16'h0020, 16'h0001, 16'h0300, 16'h0100, 16'h0002, 16'h0003};
        drive_block(b, 1'b0, 3);
        e = q.pop_front();
        n_cmp++;
        if (Done !== 1'b1 || MAX !== e.mx || Max_Number !== e.idx || Accepted !== e.acc) begin
            n_fail++;
            $display("FAIL start_ignored: done=%b max=%h idx=%0d acc=%0d want 1/%h/%0d/%0d",
                     Done, MAX, Max_Number, Accepted, e.mx, e.idx, e.acc);
        end
        step();
    endtask

    task automatic test_clear_start_idle();
        Clear = 1'b1;
        Start = 1'b1;
        step();
        Clear = 1'b0;
        Start = 1'b0;
        n_cmp++;
        if (Busy !== 1'b0 || In_Ready !== 1'b0 || MAX !== '0 || Accepted !== '0 || Max_Number !== '0) begin
            n_fail++;
            $display("FAIL clear_start: busy=%b rdy=%b max=%h acc=%0d idx=%0d want idle zeros",
                     Busy, In_Ready, MAX, Accepted, Max_Number);
        end
    endtask

    task automatic test_abort();
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            In_Valid = 1'b1;
            In_Data  = DW'((i + 1) * 16);
            step();
        end
        In_Valid = 1'b0;
        n_cmp++;
        if (MAX !== 16'h0040 || Accepted !== 4'd4 || Max_Number !== 3'd3) begin
            n_fail++;
            $display("FAIL abort_pre: max=%h acc=%0d idx=%0d want 0040/4/3", MAX, Accepted, Max_Number);
        end
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        n_cmp++;
        if (MAX !== '0 || Accepted !== '0 || Busy !== 1'b0 || In_Ready !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_post: max=%h acc=%0d busy=%b rdy=%b done=%b want zeros",
                     MAX, Accepted, Busy, In_Ready, Done);
        end
        // Clear landing on the final transfer suppresses Done.
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < CNT; i++) begin
            In_Valid = 1'b1;
            In_Data  = 16'h1234;
            Clear    = (i == CNT - 1);
            step();
        end
        In_Valid = 1'b0;
        Clear    = 1'b0;
        n_cmp++;
        if (Done !== 1'b0 || MAX !== '0 || Accepted !== '0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_final: done=%b max=%h acc=%0d busy=%b want 0/0/0/0", Done, MAX, Accepted, Busy);
        end
        step();
        n_cmp++;
        if (Done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_final_late: done=%b want 0", Done);
        end
    endtask

    task automatic test_rst_mid();
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            In_Valid = 1'b1;
            In_Data  = 16'h0077;
            step();
        end
        In_Valid = 1'b0;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (MAX !== '0 || Accepted !== '0 || Busy !== 1'b0 || In_Ready !== 1'b0 || Max_Number !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: max=%h acc=%0d busy=%b rdy=%b idx=%0d want zeros",
                     MAX, Accepted, Busy, In_Ready, Max_Number);
        end
        step();
        RST = 1'b0;
        step();
    endtask

    task automatic test_signed_data();
        blk_t b;
        exp_t e;
        b = '{16'hFFFF, 16'h0001, 16'h8000, 16'h0000, 16'h8001, 16'hFFFE, 16'h0000, 16'h0001};
        drive_block(b, 1'b0, -1);
        e = q.pop_front();
        n_cmp++;
        if (Done !== 1'b1 || MAX !== e.mx || Max_Number !== e.idx) begin
            n_fail++;
            $display("FAIL signed_model: done=%b max=%h idx=%0d want 1/%h/%0d", Done, MAX, Max_Number, e.mx, e.idx);
        end
        n_cmp++;
`ifdef MAX_SCAN_SIGNED_EN
        if (MAX !== 16'h0001 || Max_Number !== 3'd1) begin
            n_fail++;
            $display("FAIL signed_const: max=%h idx=%0d want 0001/1", MAX, Max_Number);
        end
`else
        if (MAX !== 16'hFFFF || Max_Number !== 3'd0) begin
            n_fail++;
            $display("FAIL unsigned_const: max=%h idx=%0d want ffff/0", MAX, Max_Number);
        end
`endif
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_ties();
        test_bubbles();
        test_start_ignored();
        test_clear_start_idle();
        test_abort();
        test_rst_mid();
        test_signed_data();
        n_cmp++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
